// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the scan serializer: state encoding and the
// select-width to data-width helper.
package mux_scan_serializer_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  function automatic int sel_to_width(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational WIDTH:1 selector. The one-hot AND-OR form keeps it a flat
// mux tree with no priority chain.
module mux_sel_n
  import mux_scan_serializer_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [sel_to_width(SEL_W)-1:0] i_data,
  input  logic [SEL_W-1:0]               i_sel,
  output logic                           o_bit
);

  localparam int WIDTH = sel_to_width(SEL_W);

  logic [WIDTH-1:0] w_hit;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hit
    assign w_hit[gi] = i_data[gi] & (i_sel == SEL_W'(gi));
  end

  assign o_bit = |w_hit;

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end: holds an accepted word and walks the mux
// select across it, one bit per clock, with valid/last framing.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sel_to_width(SEL_W)-1:0] in_data,
  output logic [SEL_W-1:0]               sel,
  output logic                           ser_out,
  output logic                           ser_valid,
  output logic                           ser_last,
  output logic                           busy
);

  localparam int WIDTH = sel_to_width(SEL_W);
  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_TERM  = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data_q;
  logic [SEL_W-1:0] r_sel;

  logic w_busy;
  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_bit;

  assign w_busy     = (r_state == SHIFT);
  assign w_last     = w_busy && (r_sel == SEL_TERM);
  // Ready on the last bit lets the next word reload with no idle bubble.
  assign w_in_ready = !w_busy || w_last;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data_q <= '0;
      r_sel    <= '0;
    end else if (w_accept) begin
      r_state  <= SHIFT;
      r_data_q <= in_data;
      r_sel    <= SEL_FIRST;
    end else if (w_last) begin
      // Select parks on the terminal index until the next word arrives.
      r_state <= IDLE;
    end else if (w_busy) begin
      r_sel <= MSB_FIRST ? r_sel - SEL_W'(1) : r_sel + SEL_W'(1);
    end
  end

  mux_sel_n #(
    .SEL_W (SEL_W)
  ) u_mux (
    .i_data (r_data_q),
    .i_sel  (r_sel),
    .o_bit  (w_bit)
  );

  assign in_ready  = w_in_ready;
  assign sel       = r_sel;
  assign ser_out   = w_busy & w_bit;
  assign ser_valid = w_busy;
  assign ser_last  = w_last;
  assign busy      = w_busy;

endmodule
